// File: rtl/usb_dword_adapter.sv
// Splits one 32-bit CPU register access into one or two 16-bit bridge
// transactions (low half first) and merges read halves; a watchdog aborts stuck halves.
module usb_dword_adapter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [17:0] s_addr,
  input  logic [31:0] s_wdata,
  input  logic [3:0]  s_wstrb,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [31:0] s_rdata,
  output logic [18:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        m_valid,
  input  logic        m_ready,
  input  logic [31:0] m_rdata,
  output logic        err,
  input  logic        err_clr,
  output logic [1:0]  dbg_state_o
);

  // Handshakes: s_valid is held until the one-cycle s_ready pulse; m_valid is
  // held with a stable payload until m_ready is sampled high, and drops on that edge.
  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q;
  logic [15:0] word_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [15:0] wd_q;
  logic        s_ready_q;
  logic [31:0] s_rdata_q;
  logic [18:0] m_addr_q;
  logic [31:0] m_wdata_q;
  logic [3:0]  m_wstrb_q;
  logic        m_valid_q;
  logic        err_q;

  logic        is_read;
  logic        need_hi;
  logic        unused_bits;

  assign is_read     = (wstrb_q == 4'b0000);
  assign need_hi     = is_read || (wstrb_q[3:2] != 2'b00);
  assign unused_bits = ^{m_rdata[31:16], s_addr[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      word_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      wd_q      <= '0;
      s_ready_q <= 1'b0;
      s_rdata_q <= '0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_wstrb_q <= '0;
      m_valid_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (err_clr) begin
        err_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (s_valid && !s_ready_q) begin
            word_q    <= s_addr[17:2];
            wdata_q   <= s_wdata;
            wstrb_q   <= s_wstrb;
            s_rdata_q <= '0;
            wd_q      <= '0;
            m_valid_q <= 1'b1;
            m_wstrb_q <= (s_wstrb != 4'b0000) ? 4'b0011 : 4'b0000;
            // A write touching only the upper bytes skips the low half entirely.
            if ((s_wstrb[1:0] == 2'b00) && (s_wstrb[3:2] != 2'b00)) begin
              state_q   <= HI;
              m_addr_q  <= {s_addr[17:2], 1'b1, 2'b00};
              m_wdata_q <= {16'd0, s_wdata[31:16]};
            end else begin
              state_q   <= LO;
              m_addr_q  <= {s_addr[17:2], 1'b0, 2'b00};
              m_wdata_q <= {16'd0, s_wdata[15:0]};
            end
          end
        end
        LO, HI: begin
          if (!m_valid_q) begin
            // Gap cycle after the low half completes; the high half starts fresh.
            m_valid_q <= 1'b1;
            wd_q      <= '0;
          end else if (m_ready) begin
            m_valid_q <= 1'b0;
            if (is_read) begin
              if (state_q == LO) s_rdata_q[15:0]  <= m_rdata[15:0];
              else               s_rdata_q[31:16] <= m_rdata[15:0];
            end
            if ((state_q == LO) && need_hi) begin
              state_q   <= HI;
              m_addr_q  <= {word_q, 1'b1, 2'b00};
              m_wdata_q <= {16'd0, wdata_q[31:16]};
            end else begin
              state_q   <= DONE;
              s_ready_q <= 1'b1;
            end
          end else if (wd_q == WD_LAST) begin
            m_valid_q <= 1'b0;
            err_q     <= 1'b1;
            s_rdata_q <= 32'hFFFF_FFFF;
            state_q   <= DONE;
            s_ready_q <= 1'b1;
          end else begin
            wd_q <= wd_q + 16'd1;
          end
        end
        DONE: begin
          s_ready_q <= 1'b0;
          state_q   <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign s_ready     = s_ready_q;
  assign s_rdata     = s_rdata_q;
  assign m_addr      = m_addr_q;
  assign m_wdata     = m_wdata_q;
  assign m_wstrb     = m_wstrb_q;
  assign m_valid     = m_valid_q;
  assign err         = err_q;
  assign dbg_state_o = state_q;

endmodule
